deserializer_1to16: RTL and testbench

// - Inverse of the 16:1 lane multiplexer: accepts a stream of M-bit words on a valid/ready input
//   and assembles them into one 16*M-bit frame; word k lands in out_data[k*M +: M].
// - Sits where a narrow datapath result stream must be widened back into a 16-lane vector for the

---
 rtl/deserializer_1to16_pkg.sv | 17 +
 rtl/deser_fill_buffer.sv | 47 ++++
 rtl/deserializer_1to16.sv | 119 +++++++++++
 tb/tb_deserializer_1to16.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/deserializer_1to16_pkg.sv
// Shared constants and types for the 1:16 lane deserializer.
package deserializer_1to16_pkg;

  localparam int unsigned NUM_LANES  = 16;
  localparam int unsigned LANE_IDX_W = 4;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_e;

  // One-hot lane select used to build the per-lane valid mask.
  function automatic logic [NUM_LANES-1:0] lane_bit(input logic [LANE_IDX_W-1:0] idx);
    return NUM_LANES'(1) << idx;
  endfunction

endpackage

// File: rtl/deser_fill_buffer.sv
// Frame assembly storage: 16 lane registers plus a written-lane mask,
// written one lane at a time and cleared in one cycle.
module deser_fill_buffer
  import deserializer_1to16_pkg::*;
#(
  parameter int unsigned M = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en_i,
  input  logic [LANE_IDX_W-1:0]   wr_idx_i,
  input  logic [M-1:0]            wr_data_i,
  input  logic                    clr_i,
  output logic [NUM_LANES*M-1:0]  data_o,
  output logic [NUM_LANES-1:0]    mask_o
);

  logic [NUM_LANES-1:0][M-1:0] lanes_q, lanes_d;
  logic [NUM_LANES-1:0]        mask_q, mask_d;

  // Clear takes priority so a closing frame never leaks into the next one.
  always_comb begin
    lanes_d = lanes_q;
    mask_d  = mask_q;
    if (clr_i) begin
      lanes_d = '0;
      mask_d  = '0;
    end else if (wr_en_i) begin
      lanes_d[wr_idx_i] = wr_data_i;
      mask_d            = mask_q | lane_bit(wr_idx_i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lanes_q <= '0;
      mask_q  <= '0;
    end else begin
      lanes_q <= lanes_d;
      mask_q  <= mask_d;
    end
  end

  assign data_o = lanes_q;
  assign mask_o = mask_q;

endmodule

// File: rtl/deserializer_1to16.sv
// Widens a valid/ready stream of M-bit words into 16-lane frames, with early
// close via in_last and a second frame buffered while the output is stalled.
module deserializer_1to16
  import deserializer_1to16_pkg::*;
#(
  parameter int unsigned M = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [M-1:0]            in_data_i,
  input  logic                    in_valid_i,
  input  logic                    in_last_i,
  output logic                    in_ready_o,
  output logic [NUM_LANES*M-1:0]  out_data_o,
  output logic [NUM_LANES-1:0]    out_mask_o,
  output logic                    out_valid_o,
  input  logic                    out_ready_i
);

  state_e                      state_q, state_d;
  logic [LANE_IDX_W-1:0]       cnt_q, cnt_d;
  logic [NUM_LANES*M-1:0]      out_data_q, out_data_d;
  logic [NUM_LANES-1:0]        out_mask_q, out_mask_d;
  logic                        out_valid_q, out_valid_d;

  logic                        fb_wr, fb_clr;
  logic [NUM_LANES*M-1:0]      fb_data;
  logic [NUM_LANES-1:0]        fb_mask;
  logic [NUM_LANES-1:0][M-1:0] merged_lanes;
  logic [NUM_LANES-1:0]        merged_mask;
  logic                        accept, emit, close;

  deser_fill_buffer #(.M(M)) u_fill (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (fb_wr),
    .wr_idx_i  (cnt_q),
    .wr_data_i (in_data_i),
    .clr_i     (fb_clr),
    .data_o    (fb_data),
    .mask_o    (fb_mask)
  );

  assign in_ready_o = (state_q == FILL) && !rst;
  assign accept     = in_valid_i && in_ready_o;
  assign emit       = out_valid_q && out_ready_i;
  assign close      = accept && ((cnt_q == LANE_IDX_W'(NUM_LANES - 1)) || in_last_i);

  // Closing word bypasses the fill buffer straight into the output register.
  always_comb begin
    merged_lanes        = fb_data;
    merged_lanes[cnt_q] = in_data_i;
    merged_mask         = fb_mask | lane_bit(cnt_q);
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    out_mask_d  = out_mask_q;
    out_valid_d = out_valid_q;
    fb_wr       = 1'b0;
    fb_clr      = 1'b0;
    if (emit) begin
      out_valid_d = 1'b0;
    end
    unique case (state_q)
      FILL: begin
        if (close) begin
          cnt_d = '0;
          if (!out_valid_q || emit) begin
            out_data_d  = merged_lanes;
            out_mask_d  = merged_mask;
            out_valid_d = 1'b1;
            fb_clr      = 1'b1;
          end else begin
            fb_wr   = 1'b1;
            state_d = HOLD;
          end
        end else if (accept) begin
          fb_wr = 1'b1;
          cnt_d = cnt_q + LANE_IDX_W'(1);
        end
      end
      HOLD: begin
        if (emit) begin
          out_data_d  = fb_data;
          out_mask_d  = fb_mask;
          out_valid_d = 1'b1;
          fb_clr      = 1'b1;
          cnt_d       = '0;
          state_d     = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FILL;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_mask_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_mask_q  <= out_mask_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_data_o  = out_data_q;
  assign out_mask_o  = out_mask_q;
  assign out_valid_o = out_valid_q;

endmodule

// File: tb/tb_deserializer_1to16.sv
// Self-checking bench: directed vector table, hold/reset sequences and random
// traffic scored against a frame-queue model of the deserializer.
module tb_deserializer_1to16;

  localparam int M  = 8;
  localparam int FW = 16 * M;

  logic          clk = 1'b0;
  logic          rst;
  logic [M-1:0]  in_data;
  logic          in_valid, in_last, in_ready;
  logic [FW-1:0] out_data;
  logic [15:0]   out_mask;
  logic          out_valid, out_ready;

  deserializer_1to16 #(.M(M)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_data_i   (in_data),
    .in_valid_i  (in_valid),
    .in_last_i   (in_last),
    .in_ready_o  (in_ready),
    .out_data_o  (out_data),
    .out_mask_o  (out_mask),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [FW-1:0] data;
    logic [15:0]   mask;
  } frame_t;

  typedef struct {
    int          n;
    logic [7:0]  base;
    logic        last;
    logic [15:0] exp_mask;
  } vec_t;

  int         checks = 0;
  int         failures = 0;
  int         frames_seen = 0;
  int         stalls = 0;
  logic [7:0] part_q[$];
  frame_t     exp_q[$];
  frame_t     mon_f;
  logic       prev_hold = 1'b0;
  logic [FW-1:0] prev_data;
  logic [15:0]   prev_mask;

  task automatic chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [FW-1:0] ramp(input logic [7:0] base, input int n);
    logic [FW-1:0] r;
    r = '0;
    for (int k = 0; k < n; k++) r[k*8 +: 8] = base + 8'(k);
    return r;
  endfunction

  // Reference model: collect accepted words, close at 16 or on last, score frames in order.
  always @(negedge clk) begin
    if (rst) begin
      part_q.delete();
      exp_q.delete();
      prev_hold = 1'b0;
      chk("rst_in_ready", FW'(in_ready), FW'(0));
    end else begin
      if (prev_hold) begin
        chk("stable_data", out_data, prev_data);
        chk("stable_mask", FW'(out_mask), FW'(prev_mask));
        chk("stable_valid", FW'(out_valid), FW'(1));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("spurious_frame", FW'(1), FW'(0));
        end else begin
          mon_f = exp_q.pop_front();
          chk("frame_data", out_data, mon_f.data);
          chk("frame_mask", FW'(out_mask), FW'(mon_f.mask));
          frames_seen++;
        end
      end
      if (in_valid && in_ready) begin
        part_q.push_back(in_data);
        if (part_q.size() == 16 || in_last) begin
          mon_f.data = '0;
          mon_f.mask = '0;
          for (int i = 0; i < part_q.size(); i++) begin
            mon_f.data[i*8 +: 8] = part_q[i];
            mon_f.mask[i]        = 1'b1;
          end
          exp_q.push_back(mon_f);
          part_q.delete();
        end
      end
      prev_hold = out_valid && !out_ready;
      prev_data = out_data;
      prev_mask = out_mask;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [7:0] d, input logic l);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    for (int w = 0; w < 200; w++) begin
      if (in_ready) break;
      stalls++;
      tick();
    end
    if (!in_ready) chk("send_timeout", FW'(in_ready), FW'(1));
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    chk("rst_out_valid", FW'(out_valid), FW'(0));
    chk("rst_out_data", out_data, FW'(0));
    chk("rst_out_mask", FW'(out_mask), FW'(0));
    chk("rst_ready_low", FW'(in_ready), FW'(0));
    rst = 1'b0;
    #1;
    chk("post_rst_ready", FW'(in_ready), FW'(1));
    tick();
  endtask

  task automatic send_ramp(input logic [7:0] base, input int n);
    for (int k = 0; k < n; k++) send_word(base + 8'(k), 1'b0);
  endtask

  vec_t vecs[5];
  logic [FW-1:0] saved;
  int f0;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b0;
    tick();
    do_reset();

    // Table of single-frame cases with out_ready held high.
    vecs[0] = '{n: 16, base: 8'h00, last: 1'b0, exp_mask: 16'hFFFF};
    vecs[1] = '{n: 3,  base: 8'hA1, last: 1'b1, exp_mask: 16'h0007};
    vecs[2] = '{n: 16, base: 8'h30, last: 1'b1, exp_mask: 16'hFFFF};
    vecs[3] = '{n: 1,  base: 8'h55, last: 1'b1, exp_mask: 16'h0001};
    vecs[4] = '{n: 15, base: 8'hC0, last: 1'b1, exp_mask: 16'h7FFF};
    out_ready = 1'b1;
    for (int v = 0; v < 5; v++) begin
      for (int k = 0; k < vecs[v].n; k++) begin
        if (k == vecs[v].n - 1) chk("valid_before_close", FW'(out_valid), FW'(0));
        send_word(vecs[v].base + 8'(k), vecs[v].last && (k == vecs[v].n - 1));
      end
      chk("close_latency", FW'(out_valid), FW'(1));
      chk("vec_mask", FW'(out_mask), FW'(vecs[v].exp_mask));
      chk("vec_data", out_data, ramp(vecs[v].base, vecs[v].n));
      tick();
      chk("single_emit", FW'(out_valid), FW'(0));
      repeat (3) tick();
      chk("no_empty_frame", FW'(out_valid), FW'(0));
    end

    // Stalled consumer: two frames buffered, then drained in order.
    out_ready = 1'b0;
    stalls = 0;
    send_ramp(8'h40, 32);
    chk("hold_no_stall", FW'(stalls), FW'(0));
    chk("hold_in_ready", FW'(in_ready), FW'(0));
    chk("hold_frame1", out_data, ramp(8'h40, 16));
    saved = out_data;
    repeat (5) tick();
    chk("hold_stable", out_data, saved);
    chk("hold_in_ready2", FW'(in_ready), FW'(0));
    out_ready = 1'b1;
    tick();
    chk("drain_valid", FW'(out_valid), FW'(1));
    chk("drain_frame2", out_data, ramp(8'h50, 16));
    chk("drain_ready", FW'(in_ready), FW'(1));
    tick();
    chk("drain_done", FW'(out_valid), FW'(0));

    // Sustained throughput.
    stalls = 0;
    f0 = frames_seen;
    send_ramp(8'h60, 64);
    tick();
    chk("stream_no_stall", FW'(stalls), FW'(0));
    chk("stream_frames", FW'(frames_seen - f0), FW'(4));

    // Reset mid-frame.
    send_ramp(8'hE0, 7);
    do_reset();
    send_ramp(8'h80, 16);
    chk("rst_frame_data", out_data, ramp(8'h80, 16));
    chk("rst_frame_mask", FW'(out_mask), FW'(16'hFFFF));
    tick();

    // Reset during HOLD.
    out_ready = 1'b0;
    send_ramp(8'h10, 32);
    chk("hold2_in_ready", FW'(in_ready), FW'(0));
    do_reset();
    out_ready = 1'b1;
    send_ramp(8'h90, 16);
    chk("rst_hold_data", out_data, ramp(8'h90, 16));
    chk("rst_hold_mask", FW'(out_mask), FW'(16'hFFFF));
    tick();

    // Random traffic against the model.
    for (int c = 0; c < 800; c++) begin
      in_valid  = ($urandom % 4) != 0;
      in_data   = 8'($urandom);
      in_last   = ($urandom % 8) == 0;
      out_ready = ($urandom % 3) != 0;
      tick();
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    repeat (5) tick();
    chk("drain_empty", FW'(exp_q.size()), FW'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
